// File: rtl/mux_4_1_rr_sequencer_pkg.sv
// mux_seq_pkg: shared types and helpers for mux_4_1_rr_sequencer.
//   state_t  : arbiter FSM state (IDLE / GRANT)
//   N_REQ    : number of requesters (fixed at 4)
//   rr_pick  : round-robin winner search starting at ptr
package mux_seq_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int N_REQ = 4;

  // Return the first requester with valid set, scanning ptr, ptr+1, ...
  // modulo 4. When nothing is valid the result is ptr; callers only use
  // it when at least one valid bit is set.
  function automatic logic [1:0] rr_pick(input logic [3:0] valid,
                                         input logic [1:0] ptr);
    logic [1:0] idx;
    logic [1:0] win;
    logic       found;
    win   = ptr;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = ptr + 2'(k);
      if (!found && valid[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/mux_4_1_rr_sequencer_if.sv
// mux_4_1_rr_sequencer_if: requester and output bus of the sequencer.
//   req_valid/req_last/req_data_0..3 : four requester streams (bit i = requester i)
//   req_ready                        : per-requester ready, at most one bit high
//   out_valid/out_data/out_last/out_src/out_ready : registered output stream
// Handshake rule for every stream here: a beat moves on a rising clock edge
// exactly when valid and ready are both high in the cycle before that edge.
// Ready may depend combinationally on state and on out_ready, never on the
// requester's own valid.
// Modports: master = requesters + downstream consumer, slave = the sequencer.
interface mux_4_1_rr_sequencer_if #(
  parameter int WIDTH = 4
);
  logic [3:0]       req_valid;
  logic [3:0]       req_last;
  logic [WIDTH-1:0] req_data_0;
  logic [WIDTH-1:0] req_data_1;
  logic [WIDTH-1:0] req_data_2;
  logic [WIDTH-1:0] req_data_3;
  logic [3:0]       req_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic [1:0]       out_src;
  logic             out_ready;

  modport master (
    output req_valid, req_last, req_data_0, req_data_1, req_data_2, req_data_3,
    output out_ready,
    input  req_ready, out_valid, out_data, out_last, out_src
  );

  modport slave (
    input  req_valid, req_last, req_data_0, req_data_1, req_data_2, req_data_3,
    input  out_ready,
    output req_ready, out_valid, out_data, out_last, out_src
  );
endinterface

// File: rtl/mux_4_1_rr_sequencer_gates.sv
// mux_4_1_gates_w: gate-level 4:1 mux built from AND/OR/NOT only.
//   d0..d3 : data lanes (WIDTH bits)
//   sel    : lane select
//   y      : selected lane
// Each lane is masked by its one-hot decoded select replicated across the
// lane width, then the masked lanes are ORed together.
module mux_4_1_gates_w #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] y
);
  logic [3:0] dec;

  assign dec[0] = ~sel[1] & ~sel[0];
  assign dec[1] = ~sel[1] &  sel[0];
  assign dec[2] =  sel[1] & ~sel[0];
  assign dec[3] =  sel[1] &  sel[0];

  assign y = (d0 & {WIDTH{dec[0]}}) |
             (d1 & {WIDTH{dec[1]}}) |
             (d2 & {WIDTH{dec[2]}}) |
             (d3 & {WIDTH{dec[3]}});
endmodule

// File: rtl/mux_4_1_rr_sequencer.sv
// mux_4_1_rr_sequencer: round-robin, packet-locked sharing of one 4:1 mux
// between four valid/ready requesters, followed by one registered output stage.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : requester streams and registered output stream (slave side)
//   sel        : current mux select (granted requester)
//   busy       : high while in GRANT
//   dbg_state  : FSM state
//   dbg_ptr    : round-robin start pointer for the next arbitration
// A grant is taken in IDLE and held until the beat flagged last transfers;
// then one IDLE cycle follows before the next arbitration. The requester just
// served gets the lowest priority next time.
module mux_4_1_rr_sequencer
  import mux_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  mux_4_1_rr_sequencer_if.slave        bus,
  output logic [1:0]                   sel,
  output logic                         busy,
  output state_t                       dbg_state,
  output logic [1:0]                   dbg_ptr
);

  state_t           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       sel_q, sel_d;

  logic             can_load;
  logic             xfer;
  logic             mux_last;
  logic [WIDTH-1:0] mux_data;

  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic             out_last_q;
  logic [1:0]       out_src_q;

  // The output register may accept a new beat when empty or draining now.
  assign can_load = ~out_valid_q | bus.out_ready;
  assign xfer     = (state_q == GRANT) & bus.req_valid[sel_q] & can_load;
  assign mux_last = bus.req_last[sel_q];

  mux_4_1_gates_w #(.WIDTH(WIDTH)) u_mux (
    .d0  (bus.req_data_0),
    .d1  (bus.req_data_1),
    .d2  (bus.req_data_2),
    .d3  (bus.req_data_3),
    .sel (sel_q),
    .y   (mux_data)
  );

  assign bus.req_ready = ((state_q == GRANT) && can_load) ? (4'b0001 << sel_q) : 4'b0000;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      sel_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
    end
  end

  // FSM next state: sel only moves on IDLE->GRANT, ptr only on packet end.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    unique case (state_q)
      IDLE: begin
        if (|bus.req_valid) begin
          sel_d   = rr_pick(bus.req_valid, ptr_q);
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (xfer && mux_last) begin
          state_d = IDLE;
          ptr_d   = sel_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output register: a load and a drain in the same cycle replace the beat,
  // keeping out_valid high for full throughput.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_src_q   <= 2'd0;
    end else if (xfer) begin
      out_valid_q <= 1'b1;
      out_data_q  <= mux_data;
      out_last_q  <= mux_last;
      out_src_q   <= sel_q;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_src   = out_src_q;

  assign sel       = sel_q;
  assign busy      = (state_q == GRANT);
  assign dbg_state = state_q;
  assign dbg_ptr   = ptr_q;

endmodule
